// File: rtl/memaccess.sv
// Memory-access stage: issues data-bus requests, aligns store data/strobes, extends load data,
// and stalls the pipeline until the bus completes. Optional MEMACCESS_MMIO_SKIP_EN drives out_skip.
module memaccess #(
    parameter logic [63:0] MMIO_BASE = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [63:0] in_pc,
    input  logic [63:0] in_aluout,
    input  logic [63:0] in_wdata,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic [2:0]  in_msize,
    input  logic [4:0]  in_dst,
    input  logic        in_reg_write,
    input  logic        in_mem_to_reg,
    input  logic        pipe_advance,
    output logic        dreq_valid,
    output logic [63:0] dreq_addr,
    output logic [2:0]  dreq_size,
    output logic [7:0]  dreq_strobe,
    output logic [63:0] dreq_data,
    input  logic        dresp_data_ok,
    input  logic [63:0] dresp_data,
    output logic        out_valid,
    output logic [63:0] out_pc,
    output logic [63:0] out_aluout,
    output logic [63:0] out_memout,
    output logic [4:0]  out_dst,
    output logic        out_reg_write,
    output logic        out_mem_to_reg,
    output logic        out_misalign,
    output logic        out_skip,
    output logic        stall
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

`ifdef MEMACCESS_MMIO_SKIP_EN
    localparam logic SKIP_EN = 1'b1;
`else
    localparam logic SKIP_EN = 1'b0;
`endif

    state_t      state, state_next;
    logic [63:0] rdata_q;
    logic        latch;
    logic        memop;
    logic [2:0]  off;
    logic        misalign;
    logic [7:0]  mask;
    logic [63:0] load_value;

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] o);
        case (size)
            2'b01:   return o[0];
            2'b10:   return |o[1:0];
            2'b11:   return |o;
            default: return 1'b0;
        endcase
    endfunction

    // Input is the response already shifted down so the addressed byte sits in lane 0.
    function automatic logic [63:0] extend(input logic [63:0] sh, input logic [2:0] funct3);
        case (funct3)
            3'b000:  return {{56{sh[7]}},  sh[7:0]};
            3'b001:  return {{48{sh[15]}}, sh[15:0]};
            3'b010:  return {{32{sh[31]}}, sh[31:0]};
            3'b100:  return {56'b0, sh[7:0]};
            3'b101:  return {48'b0, sh[15:0]};
            3'b110:  return {32'b0, sh[31:0]};
            default: return sh;
        endcase
    endfunction

    assign memop    = in_valid & (in_mem_read | in_mem_write);
    assign off      = in_aluout[2:0];
    assign misalign = misaligned(in_msize[1:0], off);

    always_comb begin
        case (in_msize[1:0])
            2'b00:   mask = 8'h01;
            2'b01:   mask = 8'h03;
            2'b10:   mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
    end

    assign dreq_addr   = in_aluout;
    assign dreq_size   = {1'b0, in_msize[1:0]};
    assign dreq_strobe = in_mem_write ? (mask << off) : 8'h00;
    assign dreq_data   = in_wdata << {off, 3'b000};

    // Stores latch zero so a store never leaks bus response data into writeback.
    assign load_value = in_mem_read ? extend(dresp_data >> {off, 3'b000}, in_msize) : 64'h0;

    assign out_pc         = in_pc;
    assign out_aluout     = in_aluout;
    assign out_dst        = in_dst;
    assign out_mem_to_reg = in_mem_to_reg;
    assign out_misalign   = memop & misalign;
    assign out_reg_write  = in_reg_write & ~out_misalign;
    assign out_skip       = SKIP_EN & memop & (in_aluout < MMIO_BASE) &
                            ((state == DONE) | ((state == IDLE) & misalign));

    always_comb begin
        state_next = state;
        latch      = 1'b0;
        dreq_valid = 1'b0;
        stall      = 1'b0;
        out_valid  = in_valid;
        out_memout = 64'h0;
        case (state)
            IDLE: begin
                if (memop && !misalign) begin
                    dreq_valid = 1'b1;
                    stall      = 1'b1;
                    out_valid  = 1'b0;
                    if (dresp_data_ok) begin
                        latch      = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                dreq_valid = 1'b1;
                stall      = 1'b1;
                out_valid  = 1'b0;
                if (dresp_data_ok) begin
                    latch      = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                // Hold here until the M/W register takes the result, so the access is not replayed.
                out_valid  = 1'b1;
                out_memout = rdata_q;
                if (pipe_advance) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rdata_q <= 64'h0;
        end else begin
            state <= state_next;
            if (latch) rdata_q <= load_value;
        end
    end

endmodule

// File: tb/tb_memaccess.sv
// Scoreboard bench for memaccess: stimulus pushes expected commits, a negedge monitor pops and checks them.
module tb_memaccess;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [63:0] in_pc, in_aluout, in_wdata;
    logic        in_mem_read, in_mem_write;
    logic [2:0]  in_msize;
    logic [4:0]  in_dst;
    logic        in_reg_write, in_mem_to_reg;
    logic        pipe_advance;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    logic        out_valid;
    logic [63:0] out_pc, out_aluout, out_memout;
    logic [4:0]  out_dst;
    logic        out_reg_write, out_mem_to_reg, out_misalign, out_skip;
    logic        stall;
    logic        hold;

    typedef struct {
        logic [63:0] alu;
        logic [63:0] mem;
        logic        rw;
        logic        mis;
    } exp_t;

    exp_t q[$];
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    // Only source of back-pressure besides this stage is the bench's hold flag.
    always_comb pipe_advance = ~stall & ~hold;

    memaccess dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_pc(in_pc), .in_aluout(in_aluout), .in_wdata(in_wdata),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_msize(in_msize),
        .in_dst(in_dst), .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
        .pipe_advance(pipe_advance),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .out_valid(out_valid), .out_pc(out_pc), .out_aluout(out_aluout),
        .out_memout(out_memout), .out_dst(out_dst), .out_reg_write(out_reg_write),
        .out_mem_to_reg(out_mem_to_reg), .out_misalign(out_misalign),
        .out_skip(out_skip), .stall(stall)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h, required %h", name, act, exp);
        else passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic v, input logic [63:0] a, input logic [63:0] wd,
                         input logic rd, input logic wr, input logic [2:0] sz, input logic rw);
        in_valid      = v;
        in_pc         = 64'h1000 + a[15:0];
        in_aluout     = a;
        in_wdata      = wd;
        in_mem_read   = rd;
        in_mem_write  = wr;
        in_msize      = sz;
        in_dst        = 5'd7;
        in_reg_write  = rw;
        in_mem_to_reg = rd;
    endtask

    task automatic push(input logic [63:0] a, input logic [63:0] m, input logic rw, input logic mis);
        exp_t e;
        e.alu = a; e.mem = m; e.rw = rw; e.mis = mis;
        q.push_back(e);
    endtask

    // Commit monitor: the M/W register loads whenever out_valid meets pipe_advance.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && pipe_advance) begin
            if (q.size() == 0) begin
                total++;
                $display("FAIL commit_unexpected: got commit alu=%h, required none", out_aluout);
            end else begin
                e = q.pop_front();
                chk("commit_alu", out_aluout, e.alu);
                chk("commit_memout", out_memout, e.mem);
                chk("commit_reg_write", 64'(out_reg_write), 64'(e.rw));
                chk("commit_misalign", 64'(out_misalign), 64'(e.mis));
            end
        end
    end

    initial begin
        logic [63:0] held;
        reset = 1'b1; hold = 1'b0;
        dresp_data_ok = 1'b0; dresp_data = 64'h0;
        instr(1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 3'b000, 1'b0);
        step(); step();
        reset = 1'b0;
        @(negedge clk);
        chk("reset_stall", 64'(stall), 64'h0);
        chk("reset_dreq_valid", 64'(dreq_valid), 64'h0);
        chk("reset_out_valid", 64'(out_valid), 64'h0);

        // ADD passthrough
        step();
        instr(1'b1, 64'h1234, 64'h0, 1'b0, 1'b0, 3'b000, 1'b1);
        push(64'h1234, 64'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk("add_stall", 64'(stall), 64'h0);
        chk("add_dreq_valid", 64'(dreq_valid), 64'h0);
        chk("add_out_valid", 64'(out_valid), 64'h1);

        // LB, data_ok on the 4th stalled cycle
        step();
        instr(1'b1, 64'h8000_0003, 64'h0, 1'b1, 1'b0, 3'b000, 1'b1);
        dresp_data = 64'h0000_0000_8000_0000;
        push(64'h8000_0003, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            dresp_data_ok = (i == 3);
            @(negedge clk);
            chk("lb_stall", 64'(stall), 64'h1);
            chk("lb_dreq_valid", 64'(dreq_valid), 64'h1);
            chk("lb_strobe", 64'(dreq_strobe), 64'h0);
            step();
        end
        dresp_data_ok = 1'b0;
        @(negedge clk);
        chk("lb_done_stall", 64'(stall), 64'h0);
        chk("lb_done_dreq_valid", 64'(dreq_valid), 64'h0);

        // LWU, data_ok together with the request
        step();
        instr(1'b1, 64'h8000_0004, 64'h0, 1'b1, 1'b0, 3'b110, 1'b1);
        dresp_data = 64'hDEAD_BEEF_0000_0000;
        dresp_data_ok = 1'b1;
        push(64'h8000_0004, 64'h0000_0000_DEAD_BEEF, 1'b1, 1'b0);
        @(negedge clk);
        chk("lwu_stall", 64'(stall), 64'h1);
        step();
        dresp_data_ok = 1'b0;
        @(negedge clk);
        chk("lwu_done_out_valid", 64'(out_valid), 64'h1);
        chk("lwu_done_stall", 64'(stall), 64'h0);

        // SH: lane-aligned data and strobe, response data ignored
        step();
        instr(1'b1, 64'h8000_0006, 64'hABCD, 1'b0, 1'b1, 3'b001, 1'b0);
        dresp_data = 64'hFFFF_FFFF_FFFF_FFFF;
        push(64'h8000_0006, 64'h0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            dresp_data_ok = (i == 1);
            @(negedge clk);
            chk("sh_strobe", 64'(dreq_strobe), 64'hC0);
            chk("sh_data", dreq_data, 64'hABCD_0000_0000_0000);
            chk("sh_size", 64'(dreq_size), 64'h1);
            chk("sh_dreq_valid", 64'(dreq_valid), 64'h1);
            step();
        end
        dresp_data_ok = 1'b0;
        @(negedge clk);

        // LW misaligned
        step();
        instr(1'b1, 64'h8000_0002, 64'h0, 1'b1, 1'b0, 3'b010, 1'b1);
        push(64'h8000_0002, 64'h0, 1'b0, 1'b1);
        @(negedge clk);
        chk("lw_mis_flag", 64'(out_misalign), 64'h1);
        chk("lw_mis_reg_write", 64'(out_reg_write), 64'h0);
        chk("lw_mis_dreq_valid", 64'(dreq_valid), 64'h0);
        chk("lw_mis_stall", 64'(stall), 64'h0);

        // LD aborted by reset while in WAIT; stale data_ok afterwards is ignored
        step();
        instr(1'b1, 64'h8000_0008, 64'h0, 1'b1, 1'b0, 3'b011, 1'b1);
        @(negedge clk);
        chk("ld_issue_dreq_valid", 64'(dreq_valid), 64'h1);
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("ld_wait_stall", 64'(stall), 64'h1);
        step();
        reset = 1'b0;
        instr(1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 3'b000, 1'b0);
        dresp_data_ok = 1'b1;
        @(negedge clk);
        chk("rst_wait_dreq_valid", 64'(dreq_valid), 64'h0);
        chk("rst_wait_stall", 64'(stall), 64'h0);
        step();
        dresp_data_ok = 1'b0;
        @(negedge clk);
        chk("stale_ok_out_valid", 64'(out_valid), 64'h0);
        chk("stale_ok_dreq_valid", 64'(dreq_valid), 64'h0);

        // LH held in DONE for two cycles without advance
        step();
        instr(1'b1, 64'h8000_000A, 64'h0, 1'b1, 1'b0, 3'b001, 1'b1);
        dresp_data = 64'h0000_0000_F00D_0000;
        dresp_data_ok = 1'b1;
        push(64'h8000_000A, 64'hFFFF_FFFF_FFFF_F00D, 1'b1, 1'b0);
        @(negedge clk);
        step();
        hold = 1'b1;
        for (int i = 0; i < 2; i++) begin
            dresp_data = 64'h1111_2222_3333_4444;
            @(negedge clk);
            held = out_memout;
            chk("hold_dreq_valid", 64'(dreq_valid), 64'h0);
            chk("hold_out_valid", 64'(out_valid), 64'h1);
            chk("hold_memout", held, 64'hFFFF_FFFF_FFFF_F00D);
            step();
        end
        hold = 1'b0;
        dresp_data_ok = 1'b0;
        @(negedge clk);
        step();
        instr(1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 3'b000, 1'b0);
        @(negedge clk);
        chk("final_idle_stall", 64'(stall), 64'h0);
        step();
        chk("scoreboard_drained", 64'(q.size()), 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
